// File: rtl/mpuc_inv1307_pkg.sv
// Shared constants and stage tags for the 1/1.3066 inverse twiddle multiplier.
package mpuc_inv1307_pkg;

  localparam int unsigned K_NUM   = 50159;
  localparam int unsigned K_FRAC  = 16;
  localparam int unsigned K_ROUND = 1 << 15;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RE   = 2'd1,
    IM   = 2'd2
  } tag_e;

endpackage

// File: rtl/mpuc_k0765_lane.sv
// Single-lane x*50159/2^16 multiplier: CSD partial sums, then round-half-up and shift.
module mpuc_k0765_lane
  import mpuc_inv1307_pkg::*;
#(
  parameter int unsigned total_bits = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ED,
  input  logic signed [total_bits-1:0] x,
  input  tag_e                         tag_in,
  output logic signed [total_bits-1:0] y,
  output tag_e                         tag_out
);

  localparam int unsigned IW = total_bits + 17;

  // Guard against the CSD terms drifting away from the shared constant.
  if ((1 << 16) - (1 << 14) + (1 << 10) - (1 << 4) - 1 != K_NUM) begin : g_k_check
    $error("CSD terms do not match K_NUM");
  end

  logic signed [IW-1:0] xe;
  logic signed [IW-1:0] a_q;
  logic signed [IW-1:0] b_q;
  logic signed [IW-1:0] s;
  tag_e                 tag1_q;

  assign xe = {{17{x[total_bits-1]}}, x};
  assign s  = a_q - b_q + $signed(IW'(K_ROUND));

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      tag1_q  <= NONE;
      y       <= '0;
      tag_out <= NONE;
    end else if (ED) begin
      a_q     <= (xe <<< 16) - (xe <<< 14) + (xe <<< 10);
      b_q     <= (xe <<< 4) + xe;
      tag1_q  <= tag_in;
      y       <= total_bits'(s >>> K_FRAC);
      tag_out <= tag1_q;
    end
  end

endmodule

// File: rtl/mpuc_inv1307.sv
// Interleaved complex stream times 1/1.3066 with optional +j rotation; 3 enabled cycles latency.
module mpuc_inv1307
  import mpuc_inv1307_pkg::*;
#(
  parameter int unsigned total_bits = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ED,
  input  logic                         DS,
  input  logic                         MPYJ,
  input  logic signed [total_bits-1:0] DR,
  input  logic signed [total_bits-1:0] DI,
  output logic signed [total_bits-1:0] DOR,
  output logic signed [total_bits-1:0] DOI,
  output logic                         DV
);

  logic                         ds_q;
  logic signed [total_bits-1:0] di_q;
  logic                         mpyj_q;
  logic                         mpyj_p1_q;
  logic                         mpyj_p2_q;
  logic signed [total_bits-1:0] re_q;
  tag_e                         tag2_prev_q;

  logic signed [total_bits-1:0] lane_x;
  tag_e                         lane_tag;
  logic signed [total_bits-1:0] lane_y;
  tag_e                         lane_tag_out;
  logic                         load;

  always_comb begin
    lane_x   = DR;
    lane_tag = NONE;
    if (DS) begin
      lane_x   = DR;
      lane_tag = RE;
    end else if (ds_q) begin
      lane_x   = di_q;
      lane_tag = IM;
    end
  end

  mpuc_k0765_lane #(
    .total_bits(total_bits)
  ) u_lane (
    .CLK    (CLK),
    .RST    (RST),
    .ED     (ED),
    .x      (lane_x),
    .tag_in (lane_tag),
    .y      (lane_y),
    .tag_out(lane_tag_out)
  );

  // An orphan RE (repeated DS) never precedes an IM, so its pair is never emitted.
  assign load = (lane_tag_out == IM) && (tag2_prev_q == RE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ds_q        <= 1'b0;
      di_q        <= '0;
      mpyj_q      <= 1'b0;
      mpyj_p1_q   <= 1'b0;
      mpyj_p2_q   <= 1'b0;
      re_q        <= '0;
      tag2_prev_q <= NONE;
      DOR         <= '0;
      DOI         <= '0;
      DV          <= 1'b0;
    end else if (ED) begin
      ds_q <= DS;
      if (DS) begin
        di_q   <= DI;
        mpyj_q <= MPYJ;
      end
      // MPYJ follows the pair down the pipe so a new DS cannot overwrite it early.
      mpyj_p1_q   <= mpyj_q;
      mpyj_p2_q   <= mpyj_p1_q;
      tag2_prev_q <= lane_tag_out;
      if (lane_tag_out == RE) begin
        re_q <= lane_y;
      end
      DV <= load;
      if (load) begin
        if (mpyj_p2_q) begin
          DOR <= -lane_y;
          DOI <= re_q;
        end else begin
          DOR <= re_q;
          DOI <= lane_y;
        end
      end
    end
  end

endmodule
